// File: rtl/up_sampler_n_if.sv
// Sample-path bundle for up_sampler_n.
// The master drives strobes and samples; the slave returns the up-sampled stream.
interface up_sampler_n_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 4
);
  logic                    out_en;
  logic                    x_valid;
  logic signed [WIDTH-1:0] x_in;
  logic [CNT_W-1:0]        factor_m1;
  logic                    mode;
  logic                    clear_flags;
  logic signed [WIDTH-1:0] y;
  logic                    y_valid;
  logic [CNT_W-1:0]        y_phase;
  logic                    overrun;
  logic                    underrun;

  modport master (
    output out_en, x_valid, x_in,
    output factor_m1, mode, clear_flags,
    input  y, y_valid, y_phase,
    input  overrun, underrun
  );

  modport slave (
    input  out_en, x_valid, x_in,
    input  factor_m1, mode, clear_flags,
    output y, y_valid, y_phase,
    output overrun, underrun
  );
endinterface

// File: rtl/up_sampler_n.sv
// Run-time selectable 1..MAX_FACTOR interpolating up-sampler
// (zero-stuff or sample-and-hold) with a one-entry input buffer.
module up_sampler_n #(
  parameter int WIDTH      = 18,
  parameter int MAX_FACTOR = 16,
  parameter int CNT_W      = 4
) (
  input logic           clk,
  input logic           reset,
  up_sampler_n_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_M1 =
    CNT_W'(MAX_FACTOR - 1);

  logic [CNT_W-1:0]        ph;
  logic [CNT_W-1:0]        l_lat;
  logic [CNT_W-1:0]        l_eff;
  logic [CNT_W-1:0]        f_clamp;
  logic signed [WIDTH-1:0] sbuf;
  logic signed [WIDTH-1:0] hold;
  logic signed [WIDTH-1:0] y_q;
  logic [CNT_W-1:0]        yph_q;
  logic                    full;
  logic                    yv_q;
  logic                    ov_q;
  logic                    un_q;
  logic                    consume;
  logic                    set_ov;
  logic                    set_un;

  always_comb begin
    f_clamp = bus.factor_m1;
    if (bus.factor_m1 > MAX_M1) f_clamp = MAX_M1;
    consume = bus.out_en && (ph == '0);
    // frame length is taken from the fresh factor on the tick that starts it
    l_eff  = consume ? f_clamp : l_lat;
    set_ov = bus.x_valid && full && !consume;
    set_un = consume && !full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph    <= '0;
      l_lat <= '0;
      sbuf  <= '0;
      hold  <= '0;
      full  <= 1'b0;
      y_q   <= '0;
      yv_q  <= 1'b0;
      yph_q <= '0;
      ov_q  <= 1'b0;
      un_q  <= 1'b0;
    end else begin
      yv_q <= bus.out_en;
      if (bus.out_en) begin
        yph_q <= ph;
        ph    <= (ph == l_eff) ? '0 : ph + CNT_W'(1);
        if (consume) begin
          l_lat <= f_clamp;
          y_q   <= full ? sbuf : '0;
          hold  <= full ? sbuf : '0;
        end else begin
          y_q <= bus.mode ? hold : '0;
        end
      end
      // a write on the consume edge refills the buffer after the read
      if (bus.x_valid) begin
        sbuf <= bus.x_in;
        full <= 1'b1;
      end else if (consume) begin
        full <= 1'b0;
      end
      ov_q <= set_ov | (ov_q & ~bus.clear_flags);
      un_q <= set_un | (un_q & ~bus.clear_flags);
    end
  end

  assign bus.y        = y_q;
  assign bus.y_valid  = yv_q;
  assign bus.y_phase  = yph_q;
  assign bus.overrun  = ov_q;
  assign bus.underrun = un_q;

endmodule

// File: tb/tb_up_sampler_n.sv
// Self-checking bench for up_sampler_n: behavioural frame model,
// directed scenarios with literal expectations, then random traffic.
module tb_up_sampler_n;

  localparam int WIDTH = 18;
  localparam int MAXF  = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  up_sampler_n_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  up_sampler_n #(
    .WIDTH(WIDTH),
    .MAX_FACTOR(MAXF),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // model state: a buffered sample, the frame position and length
  bit m_full;
  int m_buf;
  int m_hold;
  int m_pos;
  int m_len;
  bit m_ov;
  bit m_un;
  int e_y;
  bit e_yv;
  int e_ph;
  int got_y[$];
  int got_ph[$];

  task automatic chk(string name, int act, int req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, req, $time);
    end
  endtask

  task automatic chk_seq(string name, input int ev[$],
                         input int got[$]);
    chk({name, "_len"}, got.size(), ev.size());
    for (int i = 0; i < ev.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got[i], ev[i]);
  endtask

  always @(posedge clk) begin
    bit sov;
    bit sun;
    if (reset) begin
      m_full = 0; m_buf = 0; m_hold = 0;
      m_pos = 0; m_len = 1;
      m_ov = 0; m_un = 0;
      e_y = 0; e_yv = 0; e_ph = 0;
    end else begin
      sov = 0;
      sun = 0;
      e_yv = bus.out_en;
      if (bus.out_en) begin
        if (m_pos == 0) begin
          m_len = int'(bus.factor_m1) + 1;
          if (m_len > MAXF) m_len = MAXF;
          if (m_full) begin
            e_y = m_buf;
            m_full = 0;
          end else begin
            e_y = 0;
            sun = 1;
          end
          m_hold = e_y;
        end else begin
          e_y = bus.mode ? m_hold : 0;
        end
        e_ph = m_pos;
        m_pos = (m_pos + 1) % m_len;
      end
      if (bus.x_valid) begin
        if (m_full) sov = 1;
        m_buf = int'($signed(bus.x_in));
        m_full = 1;
      end
      m_ov = sov | (m_ov & !bus.clear_flags);
      m_un = sun | (m_un & !bus.clear_flags);
    end
    #1;
    chk("y_valid", int'(bus.y_valid), int'(e_yv));
    chk("y", int'($signed(bus.y)), e_y);
    chk("y_phase", int'(bus.y_phase), e_ph);
    chk("overrun", int'(bus.overrun), int'(m_ov));
    chk("underrun", int'(bus.underrun), int'(m_un));
    if (e_yv) begin
      got_y.push_back(e_y);
      got_ph.push_back(e_ph);
    end
  end

  task automatic step(input bit oe, input bit xv = 0,
                      input int xi = 0, input bit clr = 0);
    @(negedge clk);
    bus.out_en      = oe;
    bus.x_valid     = xv;
    bus.x_in        = WIDTH'(xi);
    bus.clear_flags = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic fresh();
    got_y.delete();
    got_ph.delete();
  endtask

  initial begin
    int ev[$];
    int vals[4];
    bus.out_en = 0;
    bus.x_valid = 0;
    bus.x_in = '0;
    bus.factor_m1 = '0;
    bus.mode = 0;
    bus.clear_flags = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_y", int'(bus.y), 0);
    chk("rst_yv", int'(bus.y_valid), 0);

    // zero-stuff x4, out_en every 4 clocks
    fresh();
    bus.mode = 0;
    bus.factor_m1 = 3;
    repeat (2) begin
      step(0, 1, 1000);
      for (int k = 0; k < 4; k++) begin
        step(1);
        repeat (3) step(0);
      end
    end
    ev = '{1000, 0, 0, 0, 1000, 0, 0, 0};
    chk_seq("s1_y", ev, got_y);
    ev = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_seq("s1_ph", ev, got_ph);
    chk("s1_ov", int'(bus.overrun), 0);
    chk("s1_un", int'(bus.underrun), 0);

    // sample-and-hold x3
    fresh();
    bus.mode = 1;
    bus.factor_m1 = 2;
    step(0, 1, -5);
    repeat (3) step(1);
    step(0, 1, 7);
    repeat (3) step(1);
    ev = '{-5, -5, -5, 7, 7, 7};
    chk_seq("s2_y", ev, got_y);

    // frame start with empty buffer
    fresh();
    bus.factor_m1 = 1;
    step(1);
    step(1);
    ev = '{0, 0};
    chk_seq("s3_y", ev, got_y);
    chk("s3_un", int'(bus.underrun), 1);
    step(0, 0, 0, 1);
    chk("s3_unclr", int'(bus.underrun), 0);

    // overwrite before consume
    fresh();
    bus.factor_m1 = 0;
    step(0, 1, 10);
    step(0, 1, 20);
    step(1);
    ev = '{20};
    chk_seq("s4_y", ev, got_y);
    chk("s4_ov", int'(bus.overrun), 1);
    step(0, 0, 0, 1);
    chk("s4_ovclr", int'(bus.overrun), 0);

    // factor change mid-frame takes effect next frame
    fresh();
    bus.factor_m1 = 1;
    step(0, 1, 3);
    step(1);
    bus.factor_m1 = 4;
    step(1);
    step(0, 1, 4);
    repeat (5) step(1);
    ev = '{3, 3, 4, 4, 4, 4, 4};
    chk_seq("s5_y", ev, got_y);
    ev = '{0, 1, 0, 1, 2, 3, 4};
    chk_seq("s5_ph", ev, got_ph);

    // pass-through, then consume and write on the same edge
    fresh();
    bus.mode = 0;
    bus.factor_m1 = 0;
    vals = '{11, -22, 33, -44};
    foreach (vals[i]) begin
      step(0, 1, vals[i]);
      step(1);
    end
    step(1, 1, 77);
    step(1);
    ev = '{11, -22, 33, -44, 0, 77};
    chk_seq("s6_y", ev, got_y);
    ev = '{0, 0, 0, 0, 0, 0};
    chk_seq("s6_ph", ev, got_ph);
    chk("s6_un", int'(bus.underrun), 1);
    chk("s6_ov", int'(bus.overrun), 0);
    step(0, 0, 0, 1);

    // factor clamps to MAX_FACTOR
    fresh();
    bus.factor_m1 = 15;
    step(0, 1, 99);
    repeat (8) step(1);
    step(0, 1, 55);
    step(1);
    ev = '{99, 0, 0, 0, 0, 0, 0, 0, 55};
    chk_seq("s7_y", ev, got_y);
    ev = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    chk_seq("s7_ph", ev, got_ph);
    repeat (7) step(1);

    // async reset mid-frame with a full buffer
    fresh();
    bus.mode = 1;
    bus.factor_m1 = 3;
    step(0, 1, 5);
    step(1);
    step(1);
    step(0, 1, 6);
    @(negedge clk);
    bus.out_en = 0;
    bus.x_valid = 0;
    reset = 1'b1;
    #1;
    chk("ar_y", int'(bus.y), 0);
    chk("ar_yv", int'(bus.y_valid), 0);
    chk("ar_ph", int'(bus.y_phase), 0);
    chk("ar_ov", int'(bus.overrun), 0);
    chk("ar_un", int'(bus.underrun), 0);
    @(negedge clk);
    reset = 1'b0;
    fresh();
    step(1);
    ev = '{0};
    chk_seq("s8_y", ev, got_y);
    ev = '{0};
    chk_seq("s8_ph", ev, got_ph);
    chk("s8_un", int'(bus.underrun), 1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.out_en      = ($urandom_range(0, 9) < 5);
      bus.x_valid     = ($urandom_range(0, 9) < 3);
      bus.x_in        = WIDTH'($urandom);
      bus.mode        = 1'($urandom_range(0, 1));
      bus.clear_flags = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0)
        bus.factor_m1 = CNT_W'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #2;
    end

    step(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
